// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (16x oversampling, 3-sample majority vote) feeding a small pop FIFO.
// Optional parity check is built when the macro UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  , output logic               parity_err
`endif
);

  // state  | meaning
  // IDLE   | waiting for a falling edge on the synchronized line
  // START  | checking the start bit; a high majority means a false start
  // DATA   | shifting in DATA_BITS payload bits, LSB first
  // PARITY | sampling the parity bit (parity builds only)
  // STOP   | evaluating the stop bit at tick 9, then straight back to IDLE
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [3:0]    TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] PRE_LOAD  = PW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  state_t                state;
  logic                  rx_meta, rx_sync, rx_prev;
  logic [PW-1:0]         presc;
  logic                  tick;
  logic [3:0]            tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_BITS-1:0]  shreg;
  logic                  samp7, samp8;
  logic                  maj;
  logic                  armed;
  logic                  start_edge;
  logic                  stop_eval;
  logic                  par_bad;
  logic                  push;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_edge = (state == S_IDLE) && armed && rx_prev && !rx_sync;

  // Down-counting prescaler; realigned to the start edge so bit sampling is centred.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      presc <= PRE_LOAD;
    else if (start_edge || presc == '0)
      presc <= PRE_LOAD;
    else
      presc <= presc - PW'(1);
  end

  assign tick      = (presc == '0);
  assign maj       = (samp7 & samp8) | (samp7 & rx_sync) | (samp8 & rx_sync);
  assign stop_eval = tick && (tick_cnt == 4'd9) && (state == S_STOP);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_bad = ((^{shreg, par_bit}) != PARITY_ODD);
`else
  assign par_bad = 1'b0;
`endif

  assign push = stop_eval && maj && !par_bad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      samp7     <= 1'b1;
      samp8     <= 1'b1;
      armed     <= 1'b1;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (!armed && rx_sync)
        armed <= 1'b1;
      if (state == S_IDLE) begin
        if (start_edge) begin
          state    <= S_START;
          tick_cnt <= '0;
          rx_busy  <= 1'b1;
        end
      end else if (tick) begin
        tick_cnt <= tick_cnt + 4'd1;
        if (tick_cnt == 4'd7) samp7 <= rx_sync;
        if (tick_cnt == 4'd8) samp8 <= rx_sync;
        case (state)
          S_START: begin
            if (tick_cnt == 4'd9 && maj) begin
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end else if (tick_cnt == TICK_LAST) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            if (tick_cnt == 4'd9)
              shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (tick_cnt == TICK_LAST) begin
              if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (tick_cnt == 4'd9)
              par_bit <= maj;
            if (tick_cnt == TICK_LAST)
              state <= S_STOP;
          end
`endif
          S_STOP: begin
            if (tick_cnt == 4'd9) begin
              state   <= S_IDLE;
              rx_busy <= 1'b0;
              if (!maj) begin
                frame_err <= 1'b1;
                armed     <= 1'b0;
              end
`ifdef UART_RX_PARITY_EN
              parity_err <= par_bad;
`endif
            end
          end
          default: begin
            state   <= S_IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic [DATA_BITS-1:0] data_hold;
  logic                 full, pop, do_push;

  assign full     = (count == CNT_FULL);
  assign rx_valid = (count != '0);
  assign pop      = rx_valid && rx_ready;
  assign do_push  = push && (!full || pop);
  // Hold the last shown byte while empty so stale slots never leak onto rx_data.
  assign rx_data  = rx_valid ? mem[rd_ptr] : data_hold;

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      data_hold <= '0;
    end else begin
      overrun   <= push && full && !pop;
      data_hold <= rx_data;
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives serial frames into uart_rx_fifo and checks received bytes, flags and busy timing.
// Expected bytes and flag counts come from a queue-based frame model (good stop/parity -> byte, else flag).
module tb_uart_rx_fifo;

  localparam int BIT_CLK = 432;
`ifdef UART_RX_PARITY_EN
  localparam bit USE_PAR = 1'b1;
`else
  localparam bit USE_PAR = 1'b0;
`endif
  localparam int STOP_IDX = USE_PAR ? 10 : 9;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int n_vec = 0;
  int n_err = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, valid_cyc = 0, got_n = 0;
  logic [7:0] got_mem [0:255];

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    , .parity_err (parity_err)
`endif
  );

  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_cnt++;
`endif
      if (rx_valid) valid_cyc++;
      if (rx_valid && rx_ready) begin
        got_mem[got_n[7:0]] = rx_data;
        got_n++;
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    wait_clk(BIT_CLK);
  endtask

  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (USE_PAR) drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  task automatic test_reset;
    wait_clk(5);
    n_vec++;
    if ({rx_valid, rx_busy, frame_err, overrun, rx_data} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%b busy=%b fe=%b ov=%b data=%h, want all 0",
               rx_valid, rx_busy, frame_err, overrun, rx_data);
    end
    reset_n = 1'b1;
    wait_clk(20);
    n_vec++;
    if ({rx_valid, rx_busy} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_after_reset: got valid=%b busy=%b, want 0 0", rx_valid, rx_busy);
    end
  endtask

  task automatic test_single;
    int b_got, b_val, b_fe, b_ov;
    b_got = got_n; b_val = valid_cyc; b_fe = fe_cnt; b_ov = ov_cnt;
    rx_ready = 1'b1;
    fork
      send_frame(8'hA5, 1'b1, even_par(8'hA5));
      begin
        wait_clk(STOP_IDX * BIT_CLK + 200);
        n_vec++;
        if (rx_busy !== 1'b1) begin
          n_err++;
          $display("FAIL busy_before_stop_eval: got %b want 1", rx_busy);
        end
        wait_clk(100);
        n_vec++;
        if (rx_busy !== 1'b0) begin
          n_err++;
          $display("FAIL busy_after_stop_eval: got %b want 0", rx_busy);
        end
      end
    join
    wait_clk(20);
    n_vec++;
    if (got_n - b_got !== 1 || got_mem[8'(b_got)] !== 8'hA5) begin
      n_err++;
      $display("FAIL single_byte: got %0d bytes first=%h, want 1 byte a5", got_n - b_got, got_mem[8'(b_got)]);
    end
    n_vec++;
    if (valid_cyc - b_val !== 1) begin
      n_err++;
      $display("FAIL single_valid_width: got %0d cycles want 1", valid_cyc - b_val);
    end
    n_vec++;
    if (fe_cnt - b_fe !== 0 || ov_cnt - b_ov !== 0) begin
      n_err++;
      $display("FAIL single_flags: got fe=%0d ov=%0d want 0 0", fe_cnt - b_fe, ov_cnt - b_ov);
    end
  endtask

  task automatic test_false_start;
    int b_val, b_fe;
    b_val = valid_cyc; b_fe = fe_cnt;
    fork
      begin
        rx = 1'b0;
        wait_clk(81);
        rx = 1'b1;
      end
      begin
        wait_clk(40);
        n_vec++;
        if (rx_busy !== 1'b1) begin
          n_err++;
          $display("FAIL false_start_busy_rise: got %b want 1", rx_busy);
        end
        wait_clk(BIT_CLK - 40);
        n_vec++;
        if (rx_busy !== 1'b0) begin
          n_err++;
          $display("FAIL false_start_busy_fall: got %b want 0", rx_busy);
        end
      end
    join
    wait_clk(BIT_CLK);
    n_vec++;
    if (valid_cyc - b_val !== 0 || fe_cnt - b_fe !== 0) begin
      n_err++;
      $display("FAIL false_start_quiet: got valid=%0d fe=%0d want 0 0", valid_cyc - b_val, fe_cnt - b_fe);
    end
  endtask

  task automatic test_frame_err;
    int b_got, b_val, b_fe, busy_seen;
    b_got = got_n; b_val = valid_cyc; b_fe = fe_cnt; busy_seen = 0;
    rx_ready = 1'b1;
    send_frame(8'h3C, 1'b0, even_par(8'h3C));
    for (int i = 0; i < 1000; i++) begin
      wait_clk(1);
      if (rx_busy) busy_seen++;
    end
    n_vec++;
    if (fe_cnt - b_fe !== 1) begin
      n_err++;
      $display("FAIL frame_err_pulse: got %0d cycles want 1", fe_cnt - b_fe);
    end
    n_vec++;
    if (valid_cyc - b_val !== 0) begin
      n_err++;
      $display("FAIL frame_err_no_valid: got %0d valid cycles want 0", valid_cyc - b_val);
    end
    n_vec++;
    if (busy_seen !== 0) begin
      n_err++;
      $display("FAIL break_no_rearm: got %0d busy cycles want 0", busy_seen);
    end
    rx = 1'b1;
    wait_clk(100);
    send_frame(8'h3C, 1'b1, even_par(8'h3C));
    wait_clk(20);
    n_vec++;
    if (got_n - b_got !== 1 || got_mem[8'(b_got)] !== 8'h3C) begin
      n_err++;
      $display("FAIL rearm_after_break: got %0d bytes first=%h, want 1 byte 3c", got_n - b_got, got_mem[8'(b_got)]);
    end
  endtask

  task automatic test_overrun;
    int b_got, b_ov;
    logic [7:0] v;
    b_got = got_n; b_ov = ov_cnt;
    rx_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      v = 8'(k);
      send_frame(v, 1'b1, even_par(v));
      if (k == 4) begin
        n_vec++;
        if (ov_cnt - b_ov !== 0) begin
          n_err++;
          $display("FAIL overrun_early: got %0d pulses after 4 bytes want 0", ov_cnt - b_ov);
        end
      end
    end
    wait_clk(50);
    n_vec++;
    if (ov_cnt - b_ov !== 1) begin
      n_err++;
      $display("FAIL overrun_pulse: got %0d pulses want 1", ov_cnt - b_ov);
    end
    n_vec++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h01) begin
      n_err++;
      $display("FAIL full_head: got valid=%b data=%h want 1 01", rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    wait_clk(20);
    n_vec++;
    if (got_n - b_got !== 4) begin
      n_err++;
      $display("FAIL overrun_pop_count: got %0d want 4", got_n - b_got);
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (got_mem[8'(b_got + k)] !== 8'(k + 1)) begin
        n_err++;
        $display("FAIL overrun_pop_%0d: got %h want %h", k, got_mem[8'(b_got + k)], 8'(k + 1));
      end
    end
    n_vec++;
    if (rx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_drained: got valid=%b want 0", rx_valid);
    end
  endtask

  task automatic test_reset_mid_frame;
    int b_got;
    logic [7:0] b;
    b = 8'h5A;
    rx_ready = 1'b0;
    send_frame(8'h33, 1'b1, even_par(8'h33));
    wait_clk(20);
    n_vec++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h33) begin
      n_err++;
      $display("FAIL pre_reset_hold: got valid=%b data=%h want 1 33", rx_valid, rx_data);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    rx = b[3];
    wait_clk(200);
    reset_n = 1'b0;
    #2;
    n_vec++;
    if ({rx_valid, rx_busy, frame_err, overrun, rx_data} !== 12'h000) begin
      n_err++;
      $display("FAIL mid_frame_reset: got valid=%b busy=%b fe=%b ov=%b data=%h, want all 0",
               rx_valid, rx_busy, frame_err, overrun, rx_data);
    end
    rx = 1'b1;
    wait_clk(10);
    reset_n = 1'b1;
    rx_ready = 1'b1;
    wait_clk(50);
    b_got = got_n;
    send_frame(8'h5A, 1'b1, even_par(8'h5A));
    wait_clk(20);
    n_vec++;
    if (got_n - b_got !== 1 || got_mem[8'(b_got)] !== 8'h5A) begin
      n_err++;
      $display("FAIL after_reset_rx: got %0d bytes first=%h, want 1 byte 5a", got_n - b_got, got_mem[8'(b_got)]);
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_q [$];
    logic [7:0] b;
    logic bad_stop, bad_par;
    int b_got, b_fe, b_pe, b_ov, fe_exp, pe_exp;
    b_got = got_n; b_fe = fe_cnt; b_pe = pe_cnt; b_ov = ov_cnt;
    fe_exp = 0; pe_exp = 0;
    rx_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      b = 8'($urandom_range(0, 255));
      bad_stop = ($urandom_range(0, 3) == 0);
      bad_par  = USE_PAR && ($urandom_range(0, 3) == 0);
      if (bad_stop) fe_exp++;
      if (bad_par) pe_exp++;
      if (!bad_stop && !bad_par) exp_q.push_back(b);
      send_frame(b, !bad_stop, even_par(b) ^ bad_par);
      rx = 1'b1;
      wait_clk(bad_stop ? $urandom_range(10, 300) : $urandom_range(0, 300));
    end
    wait_clk(50);
    n_vec++;
    if (got_n - b_got !== exp_q.size()) begin
      n_err++;
      $display("FAIL random_count: got %0d bytes want %0d", got_n - b_got, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (got_mem[8'(b_got + i)] !== exp_q[i]) begin
        n_err++;
        $display("FAIL random_byte_%0d: got %h want %h", i, got_mem[8'(b_got + i)], exp_q[i]);
      end
    end
    n_vec++;
    if (fe_cnt - b_fe !== fe_exp || pe_cnt - b_pe !== pe_exp || ov_cnt - b_ov !== 0) begin
      n_err++;
      $display("FAIL random_flags: got fe=%0d pe=%0d ov=%0d want %0d %0d 0",
               fe_cnt - b_fe, pe_cnt - b_pe, ov_cnt - b_ov, fe_exp, pe_exp);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int b_got, b_pe, b_fe;
    b_got = got_n; b_pe = pe_cnt; b_fe = fe_cnt;
    rx_ready = 1'b1;
    send_frame(8'h07, 1'b1, 1'b1);
    wait_clk(20);
    n_vec++;
    if (got_n - b_got !== 1 || got_mem[8'(b_got)] !== 8'h07 || pe_cnt - b_pe !== 0) begin
      n_err++;
      $display("FAIL parity_good: got %0d bytes first=%h pe=%0d, want 1 byte 07 pe 0",
               got_n - b_got, got_mem[8'(b_got)], pe_cnt - b_pe);
    end
    send_frame(8'h07, 1'b1, 1'b0);
    wait_clk(20);
    n_vec++;
    if (got_n - b_got !== 1 || pe_cnt - b_pe !== 1 || fe_cnt - b_fe !== 0) begin
      n_err++;
      $display("FAIL parity_bad: got bytes=%0d pe=%0d fe=%0d, want 1 1 0",
               got_n - b_got, pe_cnt - b_pe, fe_cnt - b_fe);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_false_start;
    test_frame_err;
    test_overrun;
    test_reset_mid_frame;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
